// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//   Read-port initiator for the register file. A start request walks the
//   register range first_reg..last_reg (wrapping modulo NUM_REGS). Each
//   register is read combinationally through ReadRegister/ReadData,
//   captured, and streamed out as an {out_index, out_data} beat over a
//   valid/ready interface. The register file is never written.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   start               begin a dump (sampled only while idle)
//   abort               cancel a dump in progress (no done pulse)
//   first_reg/last_reg  inclusive range, sampled together with start
//   ReadRegister        address to the register-file read port (= idx)
//   ReadData            combinational data from the read port
//   out_valid/out_ready beat handshake
//   out_index/out_data  register number and contents of the held beat
//   busy                high while reading or sending
//   done                one-cycle pulse after the last beat is accepted
module regfile_dump_reader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REGS      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDRESS_WIDTH-1:0] first_reg,
  input  logic [ADDRESS_WIDTH-1:0] last_reg,
  output logic [ADDRESS_WIDTH-1:0] ReadRegister,
  input  logic [DATA_WIDTH-1:0]    ReadData,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_index,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_t;

  // One extra bit so NUM_REGS == 2**ADDRESS_WIDTH is representable.
  localparam logic [ADDRESS_WIDTH:0]   NumRegsW = (ADDRESS_WIDTH + 1)'(NUM_REGS);
  localparam logic [ADDRESS_WIDTH-1:0] TopReg   = ADDRESS_WIDTH'(NUM_REGS - 1);

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] idx;
  logic [ADDRESS_WIDTH-1:0] last;
  logic                     rangeOk;
  logic                     handshake;

  assign ReadRegister = idx;
  assign rangeOk   = ({1'b0, first_reg} < NumRegsW) && ({1'b0, last_reg} < NumRegsW);
  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      last      <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      // Abort wins over a same-cycle handshake: that beat is dropped.
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && rangeOk) begin
            idx   <= first_reg;
            last  <= last_reg;
            busy  <= 1'b1;
            state <= READ;
          end
        end
        READ: begin
          out_data  <= ReadData;
          out_index <= idx;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (idx == last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= (idx == TopReg) ? '0 : idx + ADDRESS_WIDTH'(1);
              state <= READ;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
